vector_fetch: RTL and testbench

Interrupt/reset vector fetch sequencer for the 6502 core. On reset release, on a latched NMI edge, or on an unmasked IRQ at an instruction boundary, it reads the two-byte vector from memory over a request/valid read port. It then presents the assembled address to the program counter's parallel-load inputs with a one-cycle load strobe. It is the source of the program counter's load path for vectoring.

---
 rtl/vector_fetch.sv | 146 ++++++++++++++
 tb/tb_vector_fetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_fetch.sv
// vector_fetch: fetches the reset/NMI/IRQ vector for the 6502 core over a
// request/valid read port and hands it to the program counter's parallel load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_HOLD | reset active or just released; reset-vector fetch follows
// IDLE     | waiting for an interrupt at an instruction boundary
// REQ_LO   | requesting the vector low byte at base
// REQ_HI   | requesting the vector high byte at base+1
// LOAD     | one-cycle program counter load strobe
module vector_fetch #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC   = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        irq_mask,
  input  logic        boundary,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  output logic [7:0]  pcl_out,
  output logic [7:0]  pch_out,
  output logic        load,
  output logic        busy,
  output logic [1:0]  vec_kind
);

  localparam logic [1:0] KIND_RESET = 2'b00;
  localparam logic [1:0] KIND_NMI   = 2'b01;
  localparam logic [1:0] KIND_IRQ   = 2'b10;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    REQ_LO   = 3'd2,
    REQ_HI   = 3'd3,
    LOAD     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] base;
  logic [15:0] base_nxt;
  logic [1:0]  kind_nxt;
  logic        take_nmi;
  logic        nmi_sample;
  logic        nmi_pending;
  logic        nmi_edge;

  // A falling edge is a high sample followed by a low input in the same cycle.
  assign nmi_edge = nmi_sample & ~nmi_n;

  // State register; reset parks the sequencer ready to fetch the reset vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, including vector selection when a sequence starts.
  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    kind_nxt  = vec_kind;
    take_nmi  = 1'b0;
    case (state)
      RST_HOLD: begin
        state_nxt = REQ_LO;
        base_nxt  = RESET_VEC;
        kind_nxt  = KIND_RESET;
      end
      IDLE: begin
        if (boundary) begin
          if (nmi_pending) begin
            state_nxt = REQ_LO;
            base_nxt  = NMI_VEC;
            kind_nxt  = KIND_NMI;
            take_nmi  = 1'b1;
          end else if (!irq_n && !irq_mask) begin
            state_nxt = REQ_LO;
            base_nxt  = IRQ_VEC;
            kind_nxt  = KIND_IRQ;
          end
        end
      end
      REQ_LO: begin
        if (rd_valid) state_nxt = REQ_HI;
      end
      REQ_HI: begin
        if (rd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = RST_HOLD;
      end
    endcase
  end

  // Vector base, kind and captured bytes; bytes only move on a completed read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base     <= RESET_VEC;
      vec_kind <= KIND_RESET;
      pcl_out  <= 8'h00;
      pch_out  <= 8'h00;
    end else begin
      base     <= base_nxt;
      vec_kind <= kind_nxt;
      if (state == REQ_LO && rd_valid) pcl_out <= rd_data;
      if (state == REQ_HI && rd_valid) pch_out <= rd_data;
    end
  end

  // NMI edge latch; a new edge wins over the clear so it is never dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_sample  <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_sample <= nmi_n;
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
      end else if (take_nmi) begin
        nmi_pending <= 1'b0;
      end
    end
  end

  // Moore outputs decoded from state (and the registered base) only.
  always_comb begin
    rd_req  = (state == REQ_LO) || (state == REQ_HI);
    rd_addr = (state == REQ_HI) ? base + 16'd1 : base;
    load    = (state == LOAD);
    busy    = (state != IDLE);
  end

endmodule

// File: tb/tb_vector_fetch.sv
// Testbench for vector_fetch: memory responder with programmable wait states
// and a vector-level reference model (priority rules plus memory contents).
module tb_vector_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        nmi_n;
  logic        irq_n;
  logic        irq_mask;
  logic        boundary;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  pcl_out;
  logic [7:0]  pch_out;
  logic        load;
  logic        busy;
  logic [1:0]  vec_kind;

  int checks = 0;
  int errors = 0;

  // memory image of $FFFA..$FFFF
  logic [7:0] mem [0:5];
  int wait_lo = 0;
  int wait_hi = 0;
  bit junk_en = 1'b0;

  typedef struct {
    bit          found;
    int          cyc;
    logic [15:0] a_lo;
    logic [15:0] a_hi;
    int          lo_cnt;
    bit          early;
    logic [1:0]  kind;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        busy_after;
  } obs_t;

  vector_fetch dut (
    .clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n),
    .irq_mask(irq_mask), .boundary(boundary), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .pcl_out(pcl_out), .pch_out(pch_out), .load(load), .busy(busy),
    .vec_kind(vec_kind)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    int idx;
    idx = int'(a) - 32'hFFFA;
    if (idx >= 0 && idx <= 5) return mem[idx];
    return 8'h5A;
  endfunction

  // reference vector: high byte at base+1, low byte at base
  function automatic logic [15:0] vec_of(input logic [15:0] b);
    return {mem_rd(b + 16'd1), mem_rd(b)};
  endfunction

  // memory responder: low-byte (even) reads wait wait_lo cycles, high-byte wait_hi
  initial begin
    int cnt;
    int need;
    cnt = 0;
    rd_valid = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        need = rd_addr[0] ? wait_hi : wait_lo;
        if (cnt >= need) begin
          rd_valid = 1'b1;
          rd_data = mem_rd(rd_addr);
          cnt = 0;
        end else begin
          rd_valid = 1'b0;
          rd_data = 8'($urandom);
          cnt++;
        end
      end else begin
        cnt = 0;
        rd_valid = junk_en ? 1'($urandom) : 1'b0;
        rd_data = 8'($urandom);
      end
    end
  end

  // Follow one sequence from the cycle after its accepting edge up to load.
  task automatic observe(output obs_t o);
    logic [7:0] pcl0;
    bit first;
    first = 1'b1;
    pcl0 = 8'h00;
    o.found = 1'b0; o.cyc = 0; o.a_lo = 16'h0; o.a_hi = 16'h0; o.lo_cnt = 0;
    o.early = 1'b0; o.kind = 2'b11; o.lo = 8'h00; o.hi = 8'h00; o.busy_after = 1'b1;
    for (int i = 1; i <= 40 && !o.found; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        if (first) begin
          o.a_lo = rd_addr;
          pcl0 = pcl_out;
          first = 1'b0;
        end
        if (rd_addr == o.a_lo) begin
          o.lo_cnt++;
          if (pcl_out !== pcl0) o.early = 1'b1;
        end else begin
          o.a_hi = rd_addr;
        end
      end
      if (load === 1'b1) begin
        o.found = 1'b1; o.cyc = i; o.kind = vec_kind; o.lo = pcl_out; o.hi = pch_out;
      end
    end
    if (o.found) begin
      @(negedge clk);
      o.busy_after = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; irq_mask = 1'b1; boundary = 1'b0;
    for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_req, load, busy} !== 3'b001) begin
      errors++; $display("FAIL reset_ctrl got req/load/busy=%b want 001", {rd_req, load, busy});
    end
    checks++;
    if (rd_addr !== 16'hFFFC) begin
      errors++; $display("FAIL reset_addr got %h want fffc", rd_addr);
    end
    checks++;
    if ({vec_kind, pch_out, pcl_out} !== 18'h0) begin
      errors++; $display("FAIL reset_data got kind=%b pch=%h pcl=%h want 00/00/00", vec_kind, pch_out, pcl_out);
    end
  endtask

  task automatic test_reset_fetch();
    wait_lo = 0; wait_hi = 0;
    mem[2] = 8'h34; mem[3] = 8'h12;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_req, rd_addr, busy, vec_kind} !== {1'b1, 16'hFFFC, 1'b1, 2'b00}) begin
      errors++; $display("FAIL rf_lo got req=%b addr=%h busy=%b kind=%b want 1 fffc 1 00", rd_req, rd_addr, busy, vec_kind);
    end
    @(negedge clk);
    checks++;
    if ({rd_req, rd_addr, pcl_out} !== {1'b1, 16'hFFFD, 8'h34}) begin
      errors++; $display("FAIL rf_hi got req=%b addr=%h pcl=%h want 1 fffd 34", rd_req, rd_addr, pcl_out);
    end
    @(negedge clk);
    checks++;
    if ({load, rd_req, busy, pch_out, pcl_out, vec_kind} !== {1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 2'b00}) begin
      errors++; $display("FAIL rf_load got load=%b req=%b busy=%b pc=%h%h kind=%b want 1 0 1 1234 00", load, rd_req, busy, pch_out, pcl_out, vec_kind);
    end
    @(negedge clk);
    checks++;
    if ({load, busy, pch_out, pcl_out} !== {1'b0, 1'b0, 8'h12, 8'h34}) begin
      errors++; $display("FAIL rf_idle got load=%b busy=%b pc=%h%h want 0 0 1234", load, busy, pch_out, pcl_out);
    end
  endtask

  task automatic test_nmi();
    obs_t o;
    bit saw;
    mem[0] = 8'h00; mem[1] = 8'h90;
    nmi_n = 1'b0; boundary = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_req !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL nmi_no_boundary got activity=1 want 0");
    end
    boundary = 1'b1;
    observe(o);
    checks++;
    if (!o.found || o.cyc != 3) begin
      errors++; $display("FAIL nmi_timing got found=%b cyc=%0d want 1 3", o.found, o.cyc);
    end
    checks++;
    if ({o.kind, o.hi, o.lo, o.a_lo, o.a_hi} !== {2'b01, 16'h9000, 16'hFFFA, 16'hFFFB}) begin
      errors++; $display("FAIL nmi_vec got kind=%b pc=%h%h addr=%h/%h want 01 9000 fffa/fffb", o.kind, o.hi, o.lo, o.a_lo, o.a_hi);
    end
    checks++;
    if (o.busy_after !== 1'b0) begin
      errors++; $display("FAIL nmi_busy_after got %b want 0", o.busy_after);
    end
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rd_req !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL nmi_level_retrigger got request=1 want 0");
    end
    boundary = 1'b0; nmi_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_irq_mask();
    obs_t o;
    bit saw;
    mem[4] = 8'($urandom); mem[5] = 8'($urandom);
    irq_n = 1'b0; irq_mask = 1'b1; boundary = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rd_req !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++; $display("FAIL irq_masked got request=1 want 0");
    end
    irq_mask = 1'b0;
    observe(o);
    irq_n = 1'b1; boundary = 1'b0; irq_mask = 1'b1;
    checks++;
    if (!o.found || o.cyc != 3 || o.kind !== 2'b10) begin
      errors++; $display("FAIL irq_take got found=%b cyc=%0d kind=%b want 1 3 10", o.found, o.cyc, o.kind);
    end
    checks++;
    if ({o.hi, o.lo, o.a_lo, o.a_hi} !== {vec_of(16'hFFFE), 16'hFFFE, 16'hFFFF}) begin
      errors++; $display("FAIL irq_vec got pc=%h%h addr=%h/%h want %h fffe/ffff", o.hi, o.lo, o.a_lo, o.a_hi, vec_of(16'hFFFE));
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    obs_t o;
    for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
    boundary = 1'b0; irq_n = 1'b0; irq_mask = 1'b0; nmi_n = 1'b0;
    @(negedge clk);
    nmi_n = 1'b1;
    boundary = 1'b1;
    observe(o);
    checks++;
    if (!o.found || o.kind !== 2'b01 || {o.hi, o.lo} !== vec_of(16'hFFFA)) begin
      errors++; $display("FAIL prio_nmi_first got found=%b kind=%b pc=%h%h want 1 01 %h", o.found, o.kind, o.hi, o.lo, vec_of(16'hFFFA));
    end
    observe(o);
    irq_n = 1'b1; boundary = 1'b0;
    checks++;
    if (!o.found || o.cyc != 3 || o.kind !== 2'b10 || {o.hi, o.lo} !== vec_of(16'hFFFE)) begin
      errors++; $display("FAIL prio_irq_next got found=%b cyc=%0d kind=%b pc=%h%h want 1 3 10 %h", o.found, o.cyc, o.kind, o.hi, o.lo, vec_of(16'hFFFE));
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    obs_t o;
    irq_n = 1'b0; irq_mask = 1'b0;
    nmi_n = 1'b0; boundary = 1'b1;
    observe(o);
    irq_n = 1'b1;
    checks++;
    if (!o.found || o.kind !== 2'b10) begin
      errors++; $display("FAIL same_cycle_irq got found=%b kind=%b want 1 10", o.found, o.kind);
    end
    observe(o);
    boundary = 1'b0; nmi_n = 1'b1; irq_mask = 1'b1;
    checks++;
    if (!o.found || o.cyc != 3 || o.kind !== 2'b01) begin
      errors++; $display("FAIL same_cycle_nmi_later got found=%b cyc=%0d kind=%b want 1 3 01", o.found, o.cyc, o.kind);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    obs_t o;
    wait_lo = 3; wait_hi = 0;
    reset = 1'b0;
    @(negedge clk);
    mem[2] = 8'($urandom_range(1, 255)); mem[3] = 8'($urandom);
    reset = 1'b1;
    observe(o);
    wait_lo = 0;
    checks++;
    if (o.lo_cnt != 4 || o.a_lo !== 16'hFFFC) begin
      errors++; $display("FAIL wait_addr_hold got cycles=%0d addr=%h want 4 fffc", o.lo_cnt, o.a_lo);
    end
    checks++;
    if (o.early !== 1'b0) begin
      errors++; $display("FAIL wait_pcl_early got changed=%b want 0", o.early);
    end
    checks++;
    if (!o.found || o.cyc != 6 || {o.hi, o.lo} !== vec_of(16'hFFFC)) begin
      errors++; $display("FAIL wait_load got found=%b cyc=%0d pc=%h%h want 1 6 %h", o.found, o.cyc, o.hi, o.lo, vec_of(16'hFFFC));
    end
  endtask

  task automatic test_abort();
    obs_t o;
    bit saw;
    wait_lo = 0; wait_hi = 3;
    for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
    nmi_n = 1'b1; boundary = 1'b0;
    @(negedge clk);
    nmi_n = 1'b0;
    @(negedge clk);
    boundary = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_req, rd_addr, vec_kind} !== {1'b1, 16'hFFFA, 2'b01}) begin
      errors++; $display("FAIL abort_lo got req=%b addr=%h kind=%b want 1 fffa 01", rd_req, rd_addr, vec_kind);
    end
    nmi_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_req, rd_addr} !== {1'b1, 16'hFFFB}) begin
      errors++; $display("FAIL abort_hi got req=%b addr=%h want 1 fffb", rd_req, rd_addr);
    end
    nmi_n = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0; boundary = 1'b0;
    #1;
    checks++;
    if ({rd_req, load, busy, rd_addr, vec_kind, pch_out, pcl_out} !== {3'b001, 16'hFFFC, 2'b00, 16'h0000}) begin
      errors++; $display("FAIL abort_async got req/load/busy=%b addr=%h kind=%b pc=%h%h want 001 fffc 00 0000", {rd_req, load, busy}, rd_addr, vec_kind, pch_out, pcl_out);
    end
    nmi_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wait_hi = 0;
    reset = 1'b1;
    observe(o);
    checks++;
    if (!o.found || o.kind !== 2'b00 || {o.hi, o.lo} !== vec_of(16'hFFFC)) begin
      errors++; $display("FAIL abort_refetch got found=%b kind=%b pc=%h%h want 1 00 %h", o.found, o.kind, o.hi, o.lo, vec_of(16'hFFFC));
    end
    boundary = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_req !== 1'b0) saw = 1'b1;
    end
    boundary = 1'b0;
    checks++;
    if (saw) begin
      errors++; $display("FAIL abort_nmi_lost got request=1 want 0");
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit do_nmi, irq_low, mask, saw;
    logic [15:0] exp_base;
    logic [1:0] exp_kind;
    bit exp_take;
    junk_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
      wait_lo = $urandom_range(0, 3); wait_hi = $urandom_range(0, 3);
      do_nmi = 1'($urandom); irq_low = 1'($urandom); mask = 1'($urandom);
      irq_n = !irq_low; irq_mask = mask; boundary = 1'b0;
      if (do_nmi) begin
        nmi_n = 1'b0;
        @(negedge clk);
        nmi_n = 1'b1;
      end else begin
        @(negedge clk);
      end
      @(negedge clk);
      exp_take = 1'b1; exp_base = 16'h0000; exp_kind = 2'b00;
      if (do_nmi) begin
        exp_base = 16'hFFFA; exp_kind = 2'b01;
      end else if (irq_low && !mask) begin
        exp_base = 16'hFFFE; exp_kind = 2'b10;
      end else begin
        exp_take = 1'b0;
      end
      boundary = 1'b1;
      if (exp_take) begin
        observe(o);
        boundary = 1'b0; irq_n = 1'b1;
        checks++;
        if (!o.found || o.kind !== exp_kind || {o.hi, o.lo} !== vec_of(exp_base)
            || o.a_lo !== exp_base || o.a_hi !== exp_base + 16'd1
            || o.cyc != 3 + wait_lo + wait_hi) begin
          errors++;
          $display("FAIL rand_seq[%0d] got found=%b kind=%b pc=%h%h addr=%h/%h cyc=%0d want kind=%b pc=%h addr=%h cyc=%0d",
                   it, o.found, o.kind, o.hi, o.lo, o.a_lo, o.a_hi, o.cyc, exp_kind, vec_of(exp_base), exp_base, 3 + wait_lo + wait_hi);
        end
      end else begin
        saw = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (rd_req !== 1'b0) saw = 1'b1;
        end
        boundary = 1'b0; irq_n = 1'b1;
        checks++;
        if (saw) begin
          errors++; $display("FAIL rand_idle[%0d] got request=1 want 0 (irq_low=%b mask=%b)", it, irq_low, mask);
        end
      end
      @(negedge clk);
    end
    junk_en = 1'b0;
    wait_lo = 0; wait_hi = 0;
  endtask

  initial begin
    test_reset();
    test_reset_fetch();
    test_nmi();
    test_irq_mask();
    test_priority();
    test_same_cycle();
    test_wait_states();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
